// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the AXI traffic generator.
// State encoding, AXI constants and the write/read lane pattern.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_NEXT,
        S_DONE
    } tg_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // 32-bit lane value: burst address + beat*16 + lane index
    function automatic logic [31:0] lane_pat(
        input logic [31:0] addr,
        input logic [7:0]  beat,
        input int          lane
    );
        return addr + {20'd0, beat, 4'd0} + 32'(lane);
    endfunction

endpackage

// File: rtl/if_axi.sv
// IfAxi: AXI4 bundle between the traffic generator and a slave.
// Master drives aw/w/ar and the b/r readies; slave drives the rest.
interface IfAxi #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 28,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready,
        input  bid, bresp, bvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready,
        output bid, bresp, bvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/traffic_pattern_gen.sv
// traffic_pattern_gen: beat counter and lane pattern for one burst.
// The same counter paces W beats and checks R beats.
module traffic_pattern_gen
    import traffic_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int BURST_LEN = 16
) (
    input  logic              ui_clk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              adv,
    input  logic [31:0]       addr,
    output logic [7:0]        beat,
    output logic              last,
    output logic [DATA_W-1:0] data
);
    localparam int         LANES     = DATA_W / 32;
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    assign last = (beat == LAST_BEAT);

    // beat counter, returns to 0 after the final beat of a burst
    always_ff @(posedge ui_clk or negedge aresetn) begin
        if (!aresetn) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (adv) begin
            beat <= last ? 8'd0 : beat + 8'd1;
        end
    end

    // expected payload of the current beat
    always_comb begin
        data = '0;
        for (int k = 0; k < LANES; k++) begin
            data[k*32 +: 32] = lane_pat(addr, beat, k);
        end
    end
endmodule

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: write-then-read-back AXI burst generator with checker.
// Optional macro TRAFFIC_GEN_ERR_INJECT_EN adds err_inject (data corruption).
module axi_traffic_gen
    import traffic_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 28,
    parameter int ID_W      = 4,
    parameter int BURST_LEN = 16,
    parameter int TG_ID     = 0
) (
    input  logic              ui_clk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_bursts,
`ifdef TRAFFIC_GEN_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    IfAxi.master              ifAxi
);
    localparam int              BYTES  = BURST_LEN * DATA_W / 8;
    localparam logic [2:0]      AXSIZE = 3'($clog2(DATA_W / 8));
    localparam logic [7:0]      AXLEN  = 8'(BURST_LEN - 1);
    localparam logic [ID_W-1:0] ID     = ID_W'(TG_ID);

    tg_state_e         state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       n_total;
    logic [15:0]       n_done;
    logic [7:0]        beat;
    logic              last;
    logic [DATA_W-1:0] pat;
    logic              adv;
    logic              flip;
    logic [2:0]        err_inc;
    logic [16:0]       err_sum;

    assign adv = (state == S_W && ifAxi.wvalid && ifAxi.wready)
              || (state == S_R && ifAxi.rvalid && ifAxi.rready);

    traffic_pattern_gen #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_pat (
        .ui_clk  (ui_clk),
        .aresetn (aresetn),
        .clr     (state == S_IDLE),
        .adv     (adv),
        .addr    (32'(addr)),
        .beat    (beat),
        .last    (last),
        .data    (pat)
    );

`ifdef TRAFFIC_GEN_ERR_INJECT_EN
    logic inj_q;

    // latch the injection request with the run parameters
    always_ff @(posedge ui_clk or negedge aresetn) begin
        if (!aresetn) begin
            inj_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            inj_q <= err_inject;
        end
    end

    assign flip = inj_q && n_done == 16'd0 && beat == 8'd0;
`else
    assign flip = 1'b0;
`endif

    assign ifAxi.awid    = ID;
    assign ifAxi.awaddr  = addr;
    assign ifAxi.awlen   = AXLEN;
    assign ifAxi.awsize  = AXSIZE;
    assign ifAxi.awburst = AXI_BURST_INCR;
    assign ifAxi.wdata   = pat ^ DATA_W'(flip);
    assign ifAxi.wstrb   = '1;
    assign ifAxi.wlast   = ifAxi.wvalid && last;
    assign ifAxi.arid    = ID;
    assign ifAxi.araddr  = addr;
    assign ifAxi.arlen   = AXLEN;
    assign ifAxi.arsize  = AXSIZE;
    assign ifAxi.arburst = AXI_BURST_INCR;

    // errors found on the accepted B response or R beat this cycle
    always_comb begin
        err_inc = '0;
        if (state == S_B && ifAxi.bvalid && ifAxi.bready) begin
            err_inc = 3'(ifAxi.bresp != AXI_RESP_OKAY)
                    + 3'(ifAxi.bid != ID);
        end
        if (state == S_R && ifAxi.rvalid && ifAxi.rready) begin
            err_inc = 3'(ifAxi.rresp != AXI_RESP_OKAY)
                    + 3'(ifAxi.rid != ID)
                    + 3'(ifAxi.rdata != pat)
                    + 3'(ifAxi.rlast != last);
        end
    end

    assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

    // run sequencer: one AXI transaction outstanding at a time
    always_ff @(posedge ui_clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            addr          <= '0;
            n_total       <= '0;
            n_done        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            ifAxi.awvalid <= 1'b0;
            ifAxi.wvalid  <= 1'b0;
            ifAxi.bready  <= 1'b0;
            ifAxi.arvalid <= 1'b0;
            ifAxi.rready  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (err_inc != 3'd0) begin
                err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            end
            unique case (state)
                S_IDLE: if (start) begin
                    addr    <= base_addr;
                    n_total <= num_bursts;
                    n_done  <= '0;
                    err_cnt <= '0;
                    busy    <= 1'b1;
                    if (num_bursts == 16'd0) begin
                        state <= S_DONE;
                    end else begin
                        state         <= S_AW;
                        ifAxi.awvalid <= 1'b1;
                    end
                end
                S_AW: if (ifAxi.awready) begin
                    ifAxi.awvalid <= 1'b0;
                    ifAxi.wvalid  <= 1'b1;
                    state         <= S_W;
                end
                S_W: if (ifAxi.wready && last) begin
                    ifAxi.wvalid <= 1'b0;
                    ifAxi.bready <= 1'b1;
                    state        <= S_B;
                end
                S_B: if (ifAxi.bvalid) begin
                    ifAxi.bready  <= 1'b0;
                    ifAxi.arvalid <= 1'b1;
                    state         <= S_AR;
                end
                S_AR: if (ifAxi.arready) begin
                    ifAxi.arvalid <= 1'b0;
                    ifAxi.rready  <= 1'b1;
                    state         <= S_R;
                end
                S_R: if (ifAxi.rvalid && last) begin
                    ifAxi.rready <= 1'b0;
                    state        <= S_NEXT;
                end
                S_NEXT: begin
                    n_done <= n_done + 16'd1;
                    addr   <= addr + ADDR_W'(BYTES);
                    if (n_done + 16'd1 == n_total) begin
                        state <= S_DONE;
                    end else begin
                        state         <= S_AW;
                        ifAxi.awvalid <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: directed and randomized runs against a memory slave.
// Checks addresses, write payload, handshake rules, done/busy and err_cnt.
`timescale 1ns/1ps
module tb_axi_traffic_gen;
    localparam int DATA_W    = 256;
    localparam int ADDR_W    = 28;
    localparam int ID_W      = 4;
    localparam int BURST_LEN = 16;
    localparam int TG_ID     = 0;
    localparam int LANES     = DATA_W / 32;
    localparam int BYTES     = BURST_LEN * DATA_W / 8;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;

    typedef logic [DATA_W-1:0] vec_t;
    typedef logic [ADDR_W-1:0] adr_t;

    logic        ui_clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    adr_t        base_addr = '0;
    logic [15:0] num_bursts = '0;
`ifdef TRAFFIC_GEN_ERR_INJECT_EN
    logic        err_inject = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;

    IfAxi #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) ifAxi ();

    axi_traffic_gen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .BURST_LEN (BURST_LEN),
        .TG_ID     (TG_ID)
    ) dut (
        .ui_clk     (ui_clk),
        .aresetn    (aresetn),
        .start      (start),
        .base_addr  (base_addr),
        .num_bursts (num_bursts),
`ifdef TRAFFIC_GEN_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .busy       (busy),
        .done       (done),
        .err_cnt    (err_cnt),
        .ifAxi      (ifAxi)
    );

    always #5 ui_clk = ~ui_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slave model state
    bit   stall;
    int   berr_left, rerr_left;
    adr_t aw_q[$];
    adr_t ar_q[$];
    int   run_w, valid_cycles;
    vec_t first_w;
    bit   exp_inj;
    adr_t cur_w_addr;
    int   w_idx;
    bit   b_pend, b_hs;
    adr_t r_addr;
    int   r_idx, r_left;
    bit   r_hs;
    bit   p_aw_stall, p_w_stall, p_ar_stall;
    adr_t p_awaddr, p_araddr;
    vec_t p_wdata;
    vec_t mem [longint];

    function automatic bit go();
        return stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    endfunction

    function automatic longint key(input adr_t a, input int b);
        return longint'({a, 8'(b)});
    endfunction

    // reference payload: lane k of beat b at address A is A+16b+k
    function automatic vec_t exp_beat(input adr_t a, input int b);
        vec_t d;
        logic [31:0] a32;
        a32 = 32'(a);
        for (int k = 0; k < LANES; k++)
            d[k*32 +: 32] = a32 + 32'(b * 16) + 32'(k);
        return d;
    endfunction

    task automatic slave_idle();
        ifAxi.awready = 1'b0;
        ifAxi.wready  = 1'b0;
        ifAxi.arready = 1'b0;
        ifAxi.bvalid  = 1'b0;
        ifAxi.bid     = '0;
        ifAxi.bresp   = OKAY;
        ifAxi.rvalid  = 1'b0;
        ifAxi.rid     = '0;
        ifAxi.rdata   = '0;
        ifAxi.rresp   = OKAY;
        ifAxi.rlast   = 1'b0;
        w_idx = 0; b_pend = 0; b_hs = 0;
        r_idx = 0; r_left = 0; r_hs = 0;
        p_aw_stall = 0; p_w_stall = 0; p_ar_stall = 0;
    endtask

    task automatic slave_step();
        vec_t e;
        if (p_aw_stall) begin
            chk("aw_hold", vec_t'(ifAxi.awvalid), vec_t'(1'b1));
            chk("aw_addr_hold", vec_t'(ifAxi.awaddr), vec_t'(p_awaddr));
        end
        if (p_w_stall) begin
            chk("w_hold", vec_t'(ifAxi.wvalid), vec_t'(1'b1));
            chk("w_data_hold", ifAxi.wdata, p_wdata);
        end
        if (p_ar_stall) begin
            chk("ar_hold", vec_t'(ifAxi.arvalid), vec_t'(1'b1));
            chk("ar_addr_hold", vec_t'(ifAxi.araddr), vec_t'(p_araddr));
        end
        if (ifAxi.awvalid || ifAxi.wvalid || ifAxi.arvalid)
            valid_cycles++;
        // B channel
        if (b_hs) begin ifAxi.bvalid = 1'b0; b_hs = 0; end
        if (b_pend && !ifAxi.bvalid && go()) begin
            ifAxi.bvalid = 1'b1;
            ifAxi.bid    = ID_W'(TG_ID);
            ifAxi.bresp  = (berr_left > 0) ? SLVERR : OKAY;
            if (berr_left > 0) berr_left--;
        end
        if (ifAxi.bvalid && ifAxi.bready) begin b_hs = 1; b_pend = 0; end
        // R channel
        if (r_hs) begin ifAxi.rvalid = 1'b0; r_hs = 0; end
        if (r_left > 0 && !ifAxi.rvalid && go()) begin
            ifAxi.rvalid = 1'b1;
            ifAxi.rid    = ID_W'(TG_ID);
            ifAxi.rdata  = mem.exists(key(r_addr, r_idx))
                         ? mem[key(r_addr, r_idx)] : '0;
            ifAxi.rresp  = (rerr_left > 0) ? SLVERR : OKAY;
            if (rerr_left > 0) rerr_left--;
            ifAxi.rlast  = (r_idx == BURST_LEN - 1);
        end
        if (ifAxi.rvalid && ifAxi.rready) begin
            r_hs = 1; r_idx++; r_left--;
        end
        // W channel
        ifAxi.wready = go();
        if (ifAxi.wvalid && ifAxi.wready) begin
            e = exp_beat(cur_w_addr, w_idx);
            if (exp_inj && run_w == 0) e[0] = ~e[0];
            chk("w_data", ifAxi.wdata, e);
            chk("w_ctl", vec_t'({ifAxi.wlast, ifAxi.wstrb}),
                vec_t'({1'(w_idx == BURST_LEN - 1), {(DATA_W/8){1'b1}}}));
            if (run_w == 0) first_w = ifAxi.wdata;
            mem[key(cur_w_addr, w_idx)] = ifAxi.wdata;
            run_w++;
            w_idx++;
            if (w_idx == BURST_LEN) begin w_idx = 0; b_pend = 1; end
        end
        p_w_stall = ifAxi.wvalid && !ifAxi.wready;
        p_wdata   = ifAxi.wdata;
        // AW channel
        ifAxi.awready = go();
        if (ifAxi.awvalid && ifAxi.awready) begin
            aw_q.push_back(ifAxi.awaddr);
            cur_w_addr = ifAxi.awaddr;
            w_idx = 0;
            chk("aw_ctl",
                vec_t'({ifAxi.awid, ifAxi.awlen, ifAxi.awsize, ifAxi.awburst}),
                vec_t'({ID_W'(TG_ID), 8'(BURST_LEN - 1), 3'd5, 2'b01}));
        end
        p_aw_stall = ifAxi.awvalid && !ifAxi.awready;
        p_awaddr   = ifAxi.awaddr;
        // AR channel
        ifAxi.arready = go();
        if (ifAxi.arvalid && ifAxi.arready) begin
            chk("ar_after_b", vec_t'(b_pend || ifAxi.bvalid), vec_t'(1'b0));
            chk("ar_ctl",
                vec_t'({ifAxi.arid, ifAxi.arlen, ifAxi.arsize, ifAxi.arburst}),
                vec_t'({ID_W'(TG_ID), 8'(BURST_LEN - 1), 3'd5, 2'b01}));
            ar_q.push_back(ifAxi.araddr);
            r_addr = ifAxi.araddr;
            r_idx  = 0;
            r_left = BURST_LEN;
        end
        p_ar_stall = ifAxi.arvalid && !ifAxi.arready;
        p_araddr   = ifAxi.araddr;
    endtask

    initial begin
        slave_idle();
        forever begin
            @(negedge ui_clk);
            if (!aresetn) slave_idle();
            else slave_step();
        end
    end

    task automatic kick(input adr_t base, input int n, input bit inj);
        aw_q.delete();
        ar_q.delete();
        run_w = 0;
        valid_cycles = 0;
        first_w = '0;
`ifdef TRAFFIC_GEN_ERR_INJECT_EN
        exp_inj = inj;
        err_inject = inj;
`else
        exp_inj = 1'b0;
        if (inj) $display("[TB] err_inject not built in");
`endif
        @(negedge ui_clk);
        start = 1'b1;
        base_addr = base;
        num_bursts = 16'(n);
        @(negedge ui_clk);
        start = 1'b0;
    endtask

    task automatic run(input adr_t base, input int n, input int exp_err,
                       input bit inj, input bit poke);
        int cyc;
        adr_t a;
        kick(base, n, inj);
        chk("busy_rise", vec_t'(busy), vec_t'(1'b1));
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge ui_clk);
            cyc++;
            if (poke && cyc == 7) begin
                start = 1'b1;
                base_addr = base + adr_t'(32'h40);
                num_bursts = 16'd9;
            end
            if (poke && cyc == 8) start = 1'b0;
        end
        start = 1'b0;
        chk("done_pulse", vec_t'(done), vec_t'(1'b1));
        if (n == 0) chk("zero_latency", vec_t'(cyc), vec_t'(1));
        if (n == 0) chk("no_valid", vec_t'(valid_cycles), vec_t'(0));
        chk("busy_fall", vec_t'(busy), vec_t'(1'b0));
        chk("err_cnt", vec_t'(err_cnt), vec_t'(exp_err));
        chk("aw_count", vec_t'(aw_q.size()), vec_t'(n));
        chk("ar_count", vec_t'(ar_q.size()), vec_t'(n));
        chk("w_count", vec_t'(run_w), vec_t'(n * BURST_LEN));
        for (int i = 0; i < aw_q.size(); i++) begin
            a = base + adr_t'(i * BYTES);
            chk("aw_addr", vec_t'(aw_q[i]), vec_t'(a));
            if (i < ar_q.size()) chk("ar_addr", vec_t'(ar_q[i]), vec_t'(a));
        end
        @(negedge ui_clk);
        chk("done_one_cycle", vec_t'(done), vec_t'(1'b0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, vec_t'({busy, done, err_cnt, ifAxi.awvalid, ifAxi.wvalid,
                         ifAxi.wlast, ifAxi.bready, ifAxi.arvalid,
                         ifAxi.rready}), vec_t'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        stall = 0;
        berr_left = 0;
        rerr_left = 0;
        repeat (3) @(negedge ui_clk);
        chk_reset_outs("reset_outputs");
        chk("reset_busy", vec_t'(busy), vec_t'(1'b0));
        aresetn = 1'b1;
        @(negedge ui_clk);

        run(adr_t'(32'h1000), 1, 0, 0, 0);
        chk("beat0_lane0", vec_t'(first_w[31:0]), vec_t'(32'h1000));

        run(adr_t'(0), 4, 0, 0, 0);
        run(adr_t'(32'hFFFFE00), 3, 0, 0, 0);

        berr_left = 1;
        rerr_left = 2;
        run(adr_t'(32'h2340), 2, 3, 0, 0);
        repeat (4) @(negedge ui_clk);
        chk("err_hold", vec_t'(err_cnt), vec_t'(3));

        run(adr_t'(32'h4000), 2, 0, 0, 1);

        stall = 1;
        for (int i = 0; i < 4; i++)
            run(adr_t'($urandom), int'($urandom_range(1, 4)), 0, 0, i == 1);
        stall = 0;

        kick(adr_t'(32'h8000), 2, 0);
        cyc = 0;
        while (run_w < 5 && cyc < 2000) begin
            @(negedge ui_clk);
            cyc++;
        end
        chk("reached_beat5", vec_t'(run_w >= 5), vec_t'(1'b1));
        chk("in_w_phase", vec_t'(ifAxi.wvalid), vec_t'(1'b1));
        aresetn = 1'b0;
        #1;
        chk_reset_outs("async_reset");
        @(posedge ui_clk);
        #1;
        chk_reset_outs("reset_next_cycle");
        @(negedge ui_clk);
        aresetn = 1'b1;
        run(adr_t'(32'h8000), 2, 0, 0, 0);

        run(adr_t'(32'h500), 0, 0, 0, 0);

`ifdef TRAFFIC_GEN_ERR_INJECT_EN
        run(adr_t'(32'h3000), 2, 1, 1, 0);
        run(adr_t'(32'h3000), 1, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_traffic_gen.md
AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
- REQ-001 SHALL have parameter DATA_W, default 256, AXI data width in bits (multiple of 32).
- REQ-002 SHALL have parameter ADDR_W, default 28, AXI byte-address width.
- REQ-003 SHALL have parameter ID_W, default 4, AXI ID width.
- REQ-004 SHALL have parameter BURST_LEN, default 16, beats per burst (1..256, BURST_LEN*DATA_W/8 <= 4096).
- REQ-005 SHALL have parameter TG_ID, default 0, ID driven on awid/arid.
- REQ-006 SHALL have port ui_clk, input, 1 bit, the single clock (AXI clock).
- REQ-007 SHALL have port aresetn, input, 1 bit, asynchronous active-low reset.
- REQ-008 SHALL have port start, input, 1 bit, run request, accepted only in IDLE.
- REQ-009 SHALL have port base_addr, input, ADDR_W bits, first burst address, sampled on start.
- REQ-010 SHALL have port num_bursts, input, 16 bits, burst count, sampled on start.
- REQ-011 SHALL have port busy, output, 1 bit, high from accepted start until done.
- REQ-012 SHALL have port done, output, 1 bit, one-cycle completion pulse.
- REQ-013 SHALL have port err_cnt, output, 16 bits, saturating error count.
- REQ-014 SHALL have port ifAxi, IfAxi master side, driving aw*/w*/ar*, bready and rready.

Function
- REQ-015 SHALL use FSM IDLE->AW->W->B->AR->R->NEXT, NEXT->AW while bursts remain, else DONE->IDLE.
- REQ-016 SHALL address burst n at base_addr + n*BURST_LEN*DATA_W/8, wrapping modulo 2^ADDR_W.
- REQ-017 SHALL drive awlen/arlen=BURST_LEN-1, awsize/arsize=log2(DATA_W/8), burst=INCR, wstrb all ones.
- REQ-018 SHALL make write beat b of a burst at address A carry 32-bit lane k = A[31:0]+b*16+k (zero-extended A).
- REQ-019 SHALL hold every valid until its ready, keeping payload stable, and SHALL NOT retract valid.
- REQ-020 SHALL assert wlast only on beat BURST_LEN-1, bready only in B, and rready only in R.
- REQ-021 SHALL issue AR only after B is accepted, giving one outstanding transaction at any time.
- REQ-022 SHALL add one error each for: bresp!=OKAY, bid!=TG_ID, rresp!=OKAY, rid!=TG_ID, rdata!=expected pattern (per beat), and rlast asserted off the final beat or absent on it.
- REQ-023 SHALL saturate err_cnt at 16'hFFFF, clear it on accepted start, and hold it after done.
- REQ-024 SHALL pulse done one cycle after start, with no AXI traffic, when num_bursts=0.
- REQ-025 SHALL ignore start while busy.
- REQ-026 SHALL raise busy the cycle after start and drop it in the cycle done pulses.

Reset
- REQ-027 SHALL, on aresetn low, asynchronously force IDLE, with all valids/readies/wlast/busy/done=0, err_cnt=0 and address/beat counters=0.
- REQ-028 SHALL abandon any in-flight transaction on reset mid-burst; the slave shares aresetn.

Configuration
- REQ-029 SHALL, with TRAFFIC_GEN_ERR_INJECT_EN defined, add input err_inject (1 bit, sampled on start); when set, bit 0 of lane 0 of write beat 0 of burst 0 is inverted.
- REQ-030 SHALL, without TRAFFIC_GEN_ERR_INJECT_EN, have no err_inject port and never corrupt write data.

Structure
- REQ-031 SHALL place the state enum, AXI_RESP_OKAY, AXI_BURST_INCR and the lane-pattern function in package traffic_pkg.
- REQ-032 SHALL instantiate one sub-module, traffic_pattern_gen: a registered beat counter plus pattern output shared by the W and R phases.

Verification
- REQ-033 SHALL cover: base_addr=0x1000, num_bursts=1, AXI slave model -> 16 W beats, beat 0 lane 0=0x1000, B then AR at 0x1000, done pulse, err_cnt=0.
- REQ-034 SHALL cover: num_bursts=4, base 0x0 -> AW addresses 0x0/0x200/0x400/0x600 (DATA_W=256), err_cnt=0.
- REQ-035 SHALL cover: slave returns rresp=SLVERR on 2 beats and bresp=SLVERR once -> err_cnt=3.
- REQ-036 SHALL cover: random awready/wready/arready/rvalid stalls -> valids never drop early, data matches, err_cnt=0.
- REQ-037 SHALL cover: aresetn low during W beat 5 -> all outputs at reset values next cycle; fresh start then completes with err_cnt=0.
- REQ-038 SHALL cover: with TRAFFIC_GEN_ERR_INJECT_EN, err_inject=1, num_bursts=2 -> err_cnt=1; num_bursts=0 -> done one cycle after start with no AXI valid.
